// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, rev 1.0.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-over-fetch priority.
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_t,
  input  logic                  rst_t,
  input  logic                  if_req_t,
  input  logic [ADDR_WIDTH-1:0] if_addr_t,
  output logic                  if_gnt_t,
  output logic                  if_rvalid_t,
  output logic [DATA_WIDTH-1:0] if_rdata_t,
  input  logic                  dm_req_t,
  input  logic                  dm_we_t,
  input  logic [1:0]            dm_size_t,
  input  logic                  dm_unsigned_t,
  input  logic [ADDR_WIDTH-1:0] dm_addr_t,
  input  logic [DATA_WIDTH-1:0] dm_wdata_t,
  output logic                  dm_gnt_t,
  output logic                  dm_err_t,
  output logic                  dm_rvalid_t,
  output logic [DATA_WIDTH-1:0] dm_rdata_t,
  output logic                  mem_en_t,
  output logic                  mem_we_t,
  output logic [3:0]            mem_be_t,
  output logic [ADDR_WIDTH-1:0] mem_addr_t,
  output logic [DATA_WIDTH-1:0] mem_wdata_t,
  input  logic [DATA_WIDTH-1:0] mem_rdata_t
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_PEND = 2'd1;
  localparam logic [1:0] S_DM_PEND = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] C_WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  logic [1:0] state_q, state_d;
  logic [1:0] lane_q, lane_d;
  logic [1:0] size_q, size_d;
  logic       uns_q, uns_d;

  logic                  w_is_word, w_is_half, w_misaligned;
  logic                  w_dm_prio, w_dm_win, w_dm_load;
  logic [3:0]            w_dm_be;
  logic [DATA_WIDTH-1:0] w_dm_wdata;
  logic [DATA_WIDTH-1:0] w_lane_shift;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;

  assign w_is_word    = (dm_size_t == 2'b00);
  assign w_is_half    = dm_size_t[0];
  assign w_misaligned = (w_is_word & (|dm_addr_t[1:0])) | (w_is_half & dm_addr_t[0]);

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers whether the data port won the last contested cycle.
  logic last_dm_q;

  assign w_dm_prio = ~last_dm_q;

  always_ff @(posedge clk_t) begin
    if (rst_t) begin
      last_dm_q <= 1'b0;
    end else if (dm_req_t && if_req_t) begin
      last_dm_q <= w_dm_win;
    end
  end
`else
  assign w_dm_prio = 1'b1;
`endif

  assign w_dm_win  = dm_req_t & (w_dm_prio | ~if_req_t);
  assign w_dm_load = dm_gnt_t & ~w_misaligned & ~dm_we_t;

  always_comb begin
    w_dm_be    = 4'b1111;
    w_dm_wdata = dm_wdata_t;
    if (dm_size_t == 2'b10) begin
      w_dm_be    = 4'b0001 << dm_addr_t[1:0];
      w_dm_wdata = {4{dm_wdata_t[7:0]}};
    end else if (w_is_half) begin
      w_dm_be    = dm_addr_t[1] ? 4'b1100 : 4'b0011;
      w_dm_wdata = {2{dm_wdata_t[15:0]}};
    end
  end

  // Reset forces every grant low, which in turn keeps the memory strobes and buses at zero.
  always_comb begin
    if_gnt_t    = 1'b0;
    dm_gnt_t    = 1'b0;
    dm_err_t    = 1'b0;
    mem_en_t    = 1'b0;
    mem_we_t    = 1'b0;
    mem_be_t    = 4'b0000;
    mem_addr_t  = '0;
    mem_wdata_t = '0;
    if (!rst_t) begin
      if (w_dm_win) begin
        dm_gnt_t = 1'b1;
        dm_err_t = w_misaligned;
        if (!w_misaligned) begin
          mem_en_t    = 1'b1;
          mem_we_t    = dm_we_t;
          mem_be_t    = w_dm_be;
          mem_addr_t  = dm_addr_t & C_WORD_MASK;
          mem_wdata_t = dm_we_t ? w_dm_wdata : '0;
        end
      end else if (if_req_t) begin
        if_gnt_t   = 1'b1;
        mem_en_t   = 1'b1;
        mem_be_t   = 4'b1111;
        mem_addr_t = if_addr_t & C_WORD_MASK;
      end
    end
  end

  always_comb begin
    state_d = S_IDLE;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    if (w_dm_load) begin
      state_d = S_DM_PEND;
      lane_d  = dm_addr_t[1:0];
      size_d  = dm_size_t;
      uns_d   = dm_unsigned_t;
    end else if (if_gnt_t) begin
      state_d = S_IF_PEND;
    end
  end

  always_ff @(posedge clk_t) begin
    if (rst_t) begin
      state_q <= S_IDLE;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  assign w_lane_shift = mem_rdata_t >> {lane_q, 3'b000};
  assign w_rd_byte    = w_lane_shift[7:0];
  assign w_rd_half    = lane_q[1] ? mem_rdata_t[31:16] : mem_rdata_t[15:0];

  always_comb begin
    if_rvalid_t = 1'b0;
    if_rdata_t  = '0;
    dm_rvalid_t = 1'b0;
    dm_rdata_t  = '0;
    if (!rst_t && state_q == S_IF_PEND) begin
      if_rvalid_t = 1'b1;
      if_rdata_t  = mem_rdata_t;
    end
    if (!rst_t && state_q == S_DM_PEND) begin
      dm_rvalid_t = 1'b1;
      if (size_q == 2'b00) begin
        dm_rdata_t = mem_rdata_t;
      end else if (size_q == 2'b10) begin
        dm_rdata_t = {{24{~uns_q & w_rd_byte[7]}}, w_rd_byte};
      end else begin
        dm_rdata_t = {{16{~uns_q & w_rd_half[15]}}, w_rd_half};
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between instruction fetch and the load/store path of the RV32 core. It sits between the PC/fetch stage and the data-memory interface and the memory macro. Each cycle it grants at most one access and converts load/store size into byte enables and lane-aligned write data. It tracks the one outstanding read and routes its returned data, aligned and extended, back to the requester that owns it.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width for both requesters and the memory.
- `DATA_WIDTH`, 32, memory word width; fixed at 32 (4 byte lanes).

Ports. One clock; reset is synchronous and active-high.
- `clk_t`  in  1  clock; all state updates on the rising edge.
- `rst_t`  in  1  synchronous, active-high reset.
- `if_req_t`  in  1  fetch request; held with `if_addr_t` stable until granted.
- `if_addr_t`  in  ADDR_WIDTH  fetch byte address (word aligned).
- `if_gnt_t`  out  1  fetch granted this cycle.
- `if_rvalid_t`  out  1  fetch data valid (cycle after grant).
- `if_rdata_t`  out  32  instruction word.
- `dm_req_t`  in  1  load/store request; held stable until granted.
- `dm_we_t`  in  1  1 = store, 0 = load.
- `dm_size_t`  in  2  00 = word, 10 = byte, 01/11 = half.
- `dm_unsigned_t`  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- `dm_addr_t`  in  ADDR_WIDTH  data byte address.
- `dm_wdata_t`  in  32  store data, LSB-justified.
- `dm_gnt_t`  out  1  data access accepted this cycle; also asserted for a misaligned access.
- `dm_err_t`  out  1  misaligned access; pulses with `dm_gnt_t`.
- `dm_rvalid_t`  out  1  load data valid.
- `dm_rdata_t`  out  32  aligned, extended load data.
- `mem_en_t`  out  1  memory access strobe.
- `mem_we_t`  out  1  memory write.
- `mem_be_t`  out  4  byte enables.
- `mem_addr_t`  out  ADDR_WIDTH  word address; bits [1:0] are forced to 0.
- `mem_wdata_t`  out  32  lane-replicated write data.
- `mem_rdata_t`  in  32  read data, valid 1 cycle after `mem_en_t & ~mem_we_t`.

## Operation
Arbitration:
- Arbitration is combinational each cycle; the granted requester's fields drive the `mem_*` outputs.
- Default policy is fixed priority: the data port wins over fetch.
- A requester must keep `req` and its operands stable until `gnt`. `gnt` completes the request phase.

Byte enables and write data:
- Word: `be` = 1111. Requires `addr[1:0]` = 00.
- Half: `be` = 0011 << (2·`addr[1]`). Requires `addr[0]` = 0. Write data = {2{`wdata[15:0]`}}.
- Byte: `be` = 0001 << `addr[1:0]`. Write data = {4{`wdata[7:0]`}}.
- Fetch accesses are always word reads with `be` = 1111.

Misaligned data access:
- `dm_gnt_t` = 1 and `dm_err_t` = 1 in the same cycle.
- `mem_en_t` = 0 and no read is recorded.
- Fetch may not use the port in that cycle.

Pending-read state machine: states IDLE, IF_PEND, DM_PEND.
- Any state → IF_PEND when a fetch read is granted this cycle.
- Any state → DM_PEND when a data load is granted this cycle.
- Any state → IDLE otherwise (no read granted, a store, or an error).
- In IF_PEND: `if_rvalid_t` = 1 and `if_rdata_t` = `mem_rdata_t`.
- In DM_PEND: `dm_rvalid_t` = 1 and `dm_rdata_t` = the lane selected by the registered `addr[1:0]`/size/unsigned, extended to 32 bits.
- Read data is routed in the pending state while a new grant proceeds in the same cycle, so back-to-back reads are fully pipelined.

## Timing
- Grant latency: 0 cycles when the port is uncontested.
- Read data latency: exactly 1 cycle after grant.
- Write latency: the write commits at the grant edge.
- Throughput: 1 access per cycle.
- Simultaneous requests: the loser's `gnt` = 0 and it retries the next cycle. Under fixed priority, fetch waits for as long as `dm_req_t` is held.
- Reset values: state = IDLE.
  - All `gnt`, `rvalid`, `err` and `mem_en_t`/`mem_we_t` = 0.
  - `mem_be_t` = 0000.
  - All data/address outputs = 0.
  - Round-robin pointer favours the data port.
- Reset while a read is pending: the read is discarded; no `rvalid` occurs in the cycle after reset.
- While `rst_t` = 1: all grants are forced to 0.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: a 1-bit last-winner register.
  - When both ports request, the port that did not win last time wins.
  - The register updates only on contested grants.
  - Reset value: data wins first.
- `ARB_ROUND_ROBIN_EN` undefined: fixed data-over-fetch priority; no pointer register.

## Test plan
- Fetch alone, `if_addr_t`=0x10, memory word 0x00500093 → `if_gnt_t`=1 at cycle 0, `mem_be_t`=1111; `if_rvalid_t`=1 and `if_rdata_t`=0x00500093 at cycle 1.
- Store byte 0xA5 to 0x23 → `mem_be_t`=1000, `mem_addr_t`=0x20, `mem_wdata_t`=0xA5A5A5A5, no rvalid. Then signed byte load from 0x23 → `dm_rdata_t`=0xFFFFFFA5; unsigned byte load from 0x23 → 0x000000A5.
- Both requesting for 3 cycles → fixed: `dm_gnt_t` every cycle, `if_gnt_t`=0 throughout. With `ARB_ROUND_ROBIN_EN`: grants go dm, if, dm.
- Half load at 0x21 → `dm_gnt_t`=1, `dm_err_t`=1, `mem_en_t`=0, no `dm_rvalid_t`. A fetch requesting in that cycle is granted the next cycle.
- Back-to-back: fetch read then load on consecutive cycles → `if_rvalid_t` in cycle 1 and `dm_rvalid_t` in cycle 2, each with the correct data.
- `rst_t` asserted in the cycle after a load grant → no `dm_rvalid_t`; all outputs return to reset values.
